// File: rtl/fpu_operand_unpack_pkg.sv
// -----------------------------------------------------------------------------
// fpu_operand_unpack_pkg
//   Shared FPU class-flag header. Holds the one-hot class bit indices that the
//   execution units decode, the binary32 exponent bias and the special unbiased
//   exponent values produced by operand unpacking. Also holds the per-operand
//   unpacked record {exp, sig, cls}.
// -----------------------------------------------------------------------------
package fpu_operand_unpack_pkg;

    // One-hot class bit positions
    localparam int unsigned CLS_QNAN      = 5;
    localparam int unsigned CLS_SNAN      = 4;
    localparam int unsigned CLS_INF       = 3;
    localparam int unsigned CLS_NORMAL    = 2;
    localparam int unsigned CLS_SUBNORMAL = 1;
    localparam int unsigned CLS_ZERO      = 0;

    localparam int unsigned CLS_W = 6;
    localparam int unsigned EXP_W = 10;
    localparam int unsigned SIG_W = 24;

    // Exponent constants (unbiased, signed)
    localparam logic signed [EXP_W-1:0] EXP_BIAS    = 10'sd127;
    localparam logic signed [EXP_W-1:0] EXP_SPECIAL = 10'sd128;   // INF / NaN
    localparam logic signed [EXP_W-1:0] EXP_ZERO    = -10'sd127;
    localparam logic signed [EXP_W-1:0] EXP_SUBNORM = -10'sd126;  // before normalization

    typedef struct packed {
        logic signed [EXP_W-1:0] exp;
        logic        [SIG_W-1:0] sig;
        logic        [CLS_W-1:0] cls;
    } unpacked_op_t;

    // A subnormal still waiting for its leading one to reach the hidden-bit slot
    function automatic logic needs_shift(input unpacked_op_t op);
        return op.cls[CLS_SUBNORMAL] && !op.sig[SIG_W-1];
    endfunction

endpackage

// File: rtl/fpu_operand_decode.sv
// -----------------------------------------------------------------------------
// fpu_operand_decode
//   Purely combinational classifier for one binary32 operand. The sign bit is
//   not needed here and is carried separately by the caller.
//   Ports:
//     operand_i  in  31  exponent and fraction fields {E[7:0], F[22:0]}
//     op_o       out     {exp (signed 10), sig (24), cls (6, one-hot)}
//   Subnormals come out with exp=-126 and sig={0,F}; normalization is done
//   by the caller.
// -----------------------------------------------------------------------------
module fpu_operand_decode
    import fpu_operand_unpack_pkg::*;
(
    input  logic [30:0]  operand_i,
    output unpacked_op_t op_o
);

    logic [7:0]  e;
    logic [22:0] f;

    assign e = operand_i[30:23];
    assign f = operand_i[22:0];

    always_comb begin
        op_o = '0;
        if (e == 8'hFF) begin
            op_o.exp = EXP_SPECIAL;
            op_o.sig = {1'b1, f};
            if (f == 23'd0) begin
                op_o.cls[CLS_INF] = 1'b1;
            end else if (f[22]) begin
                op_o.cls[CLS_QNAN] = 1'b1;
            end else begin
                op_o.cls[CLS_SNAN] = 1'b1;
            end
        end else if (e == 8'h00) begin
            if (f == 23'd0) begin
                op_o.exp = EXP_ZERO;
                op_o.sig = '0;
                op_o.cls[CLS_ZERO] = 1'b1;
            end else begin
                op_o.exp = EXP_SUBNORM;
                op_o.sig = {1'b0, f};
                op_o.cls[CLS_SUBNORMAL] = 1'b1;
            end
        end else begin
            op_o.exp = $signed({2'b00, e}) - EXP_BIAS;
            op_o.sig = {1'b1, f};
            op_o.cls[CLS_NORMAL] = 1'b1;
        end
    end

endmodule

// File: rtl/fpu_operand_unpack.sv
// -----------------------------------------------------------------------------
// fpu_operand_unpack
//   Multi-cycle operand unpack stage in front of the FPU execution units.
//   Captures two raw binary32 operands and a rounding mode, classifies them,
//   unbiases exponents and normalizes subnormal significands one bit per
//   cycle so that every finite non-zero operand leaves with sig[23]=1.
//   Ports:
//     clk_i, reset_i            clock, async active-high reset
//     in_valid_i / in_ready_o   input handshake (ready only in IDLE)
//     rs1_i, rs2_i, rm_i        raw operands and rounding mode
//     out_valid_o / out_ready_i output handshake (valid only in DONE)
//     rs1_o, rs2_o, rm_o        captured raw operands / rounding mode
//     rsNExp_o, rsNSig_o,       unbiased exponent, significand with hidden
//     rsNClass_o                bit, one-hot class
// -----------------------------------------------------------------------------
module fpu_operand_unpack
    import fpu_operand_unpack_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [31:0]             rs1_i,
    input  logic [31:0]             rs2_i,
    input  logic [2:0]              rm_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [31:0]             rs1_o,
    output logic [31:0]             rs2_o,
    output logic signed [EXP_W-1:0] rs1Exp_o,
    output logic signed [EXP_W-1:0] rs2Exp_o,
    output logic [SIG_W-1:0]        rs1Sig_o,
    output logic [SIG_W-1:0]        rs2Sig_o,
    output logic [CLS_W-1:0]        rs1Class_o,
    output logic [CLS_W-1:0]        rs2Class_o,
    output logic [2:0]              rm_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_NORM = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [31:0]  raw1_q, raw1_d, raw2_q, raw2_d;
    logic [2:0]   rm_q, rm_d;
    unpacked_op_t op1_q, op1_d, op2_q, op2_d;
    unpacked_op_t dec1, dec2;

    fpu_operand_decode u_decode_rs1 (
        .operand_i (rs1_i[30:0]),
        .op_o      (dec1)
    );

    fpu_operand_decode u_decode_rs2 (
        .operand_i (rs2_i[30:0]),
        .op_o      (dec2)
    );

    always_comb begin
        state_d = state_q;
        raw1_d  = raw1_q;
        raw2_d  = raw2_q;
        rm_d    = rm_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    raw1_d  = rs1_i;
                    raw2_d  = rs2_i;
                    rm_d    = rm_i;
                    op1_d   = dec1;
                    op2_d   = dec2;
                    state_d = (dec1.cls[CLS_SUBNORMAL] || dec2.cls[CLS_SUBNORMAL])
                              ? ST_NORM : ST_DONE;
                end
            end
            ST_NORM: begin
                // Both operands shift in lockstep; one that is already
                // normalized simply holds while the other catches up.
                if (needs_shift(op1_q)) begin
                    op1_d.sig = op1_q.sig << 1;
                    op1_d.exp = op1_q.exp - 10'sd1;
                end
                if (needs_shift(op2_q)) begin
                    op2_d.sig = op2_q.sig << 1;
                    op2_d.exp = op2_q.exp - 10'sd1;
                end
                // Decide on the post-shift values so DONE follows the final shift
                if (!needs_shift(op1_d) && !needs_shift(op2_d)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register boundary: FSM state and captured/normalized operand fields
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            raw1_q  <= '0;
            raw2_q  <= '0;
            rm_q    <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
        end else begin
            state_q <= state_d;
            raw1_q  <= raw1_d;
            raw2_q  <= raw2_d;
            rm_q    <= rm_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
        end
    end

    assign in_ready_o  = (state_q == ST_IDLE);
    assign out_valid_o = (state_q == ST_DONE);

    assign rs1_o      = raw1_q;
    assign rs2_o      = raw2_q;
    assign rm_o       = rm_q;
    assign rs1Exp_o   = op1_q.exp;
    assign rs2Exp_o   = op2_q.exp;
    assign rs1Sig_o   = op1_q.sig;
    assign rs2Sig_o   = op2_q.sig;
    assign rs1Class_o = op1_q.cls;
    assign rs2Class_o = op2_q.cls;

endmodule

// File: tb/tb_fpu_operand_unpack.sv
// -----------------------------------------------------------------------------
// tb_fpu_operand_unpack
//   Directed vectors with hand-computed expected results. A driver issues
//   operations and pushes the expected response into a queue; a monitor pops
//   and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_fpu_operand_unpack;

    typedef struct {
        logic [31:0]        rs1;
        logic [31:0]        rs2;
        logic signed [9:0]  e1;
        logic signed [9:0]  e2;
        logic [23:0]        s1;
        logic [23:0]        s2;
        logic [5:0]         c1;
        logic [5:0]         c2;
        logic [2:0]         rm;
    } exp_t;

    localparam logic [5:0] C_QNAN = 6'b100000;
    localparam logic [5:0] C_SNAN = 6'b010000;
    localparam logic [5:0] C_INF  = 6'b001000;
    localparam logic [5:0] C_NORM = 6'b000100;
    localparam logic [5:0] C_SUB  = 6'b000010;
    localparam logic [5:0] C_ZERO = 6'b000001;

    logic              clk = 1'b0;
    logic              reset_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [31:0]       rs1_i, rs2_i;
    logic [2:0]        rm_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [31:0]       rs1_o, rs2_o;
    logic signed [9:0] rs1Exp_o, rs2Exp_o;
    logic [23:0]       rs1Sig_o, rs2Sig_o;
    logic [5:0]        rs1Class_o, rs2Class_o;
    logic [2:0]        rm_o;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    fpu_operand_unpack dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .rm_i        (rm_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .rs1_o       (rs1_o),
        .rs2_o       (rs2_o),
        .rs1Exp_o    (rs1Exp_o),
        .rs2Exp_o    (rs2Exp_o),
        .rs1Sig_o    (rs1Sig_o),
        .rs2Sig_o    (rs2Sig_o),
        .rs1Class_o  (rs1Class_o),
        .rs2Class_o  (rs2Class_o),
        .rm_o        (rm_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic signed [9:0] e1, input logic [23:0] s1,
                                input logic [5:0] c1,
                                input logic signed [9:0] e2, input logic [23:0] s2,
                                input logic [5:0] c2, input logic [2:0] rm);
        exp_t r;
        r.rs1 = a;  r.rs2 = b;
        r.e1 = e1;  r.s1 = s1;  r.c1 = c1;
        r.e2 = e2;  r.s2 = s2;  r.c2 = c2;
        r.rm = rm;
        return r;
    endfunction

    // Monitor: compare on every accepted output
    always @(negedge clk) begin
        if (!reset_i && out_valid_o && out_ready_i) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_output", 32'(out_valid_o), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("rs1_o",      rs1_o,              e.rs1);
                chk("rs2_o",      rs2_o,              e.rs2);
                chk("rs1Exp_o",   32'(rs1Exp_o),      32'(e.e1));
                chk("rs2Exp_o",   32'(rs2Exp_o),      32'(e.e2));
                chk("rs1Sig_o",   32'(rs1Sig_o),      32'(e.s1));
                chk("rs2Sig_o",   32'(rs2Sig_o),      32'(e.s2));
                chk("rs1Class_o", 32'(rs1Class_o),    32'(e.c1));
                chk("rs2Class_o", 32'(rs2Class_o),    32'(e.c2));
                chk("rm_o",       32'(rm_o),          32'(e.rm));
            end
        end
    end

    // Issue one operation, check its latency, optionally stall in DONE, then release.
    task automatic do_op(input exp_t e, input int lat, input bit early_rdy, input int hold);
        int n;
        logic [31:0] snap1, snap2;
        logic [23:0] snap_s1;
        logic signed [9:0] snap_e1;
        logic [2:0] snap_rm;
        @(negedge clk);
        rs1_i = e.rs1; rs2_i = e.rs2; rm_i = e.rm; in_valid_i = 1'b1;
        chk("in_ready_idle", 32'(in_ready_o), 32'd1);
        sb_q.push_back(e);
        @(posedge clk); #1;
        n = 1;
        // Garbage on the inputs while busy must be ignored
        rs1_i = 32'hDEADBEEF; rs2_i = 32'h00000003; rm_i = ~e.rm;
        if (early_rdy) out_ready_i = 1'b1;
        if (lat > 1) chk("in_ready_busy", 32'(in_ready_o), 32'd0);
        while (!out_valid_o && n < 64) begin
            @(posedge clk); #1;
            n++;
            rm_i = rm_i + 3'd1;
        end
        chk("latency", 32'(n), 32'(lat));
        in_valid_i = 1'b0;
        for (int i = 0; i < hold; i++) begin
            snap1 = rs1_o; snap2 = rs2_o; snap_s1 = rs1Sig_o; snap_e1 = rs1Exp_o; snap_rm = rm_o;
            in_valid_i = 1'b1; rs1_i = $urandom; rs2_i = $urandom; rm_i = 3'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", 32'(out_valid_o), 32'd1);
            chk("hold_ready", 32'(in_ready_o), 32'd0);
            chk("hold_stable", {rs1_o ^ snap1} | {rs2_o ^ snap2} | 32'(rs1Sig_o ^ snap_s1)
                               | 32'(rs1Exp_o ^ snap_e1) | 32'(rm_o ^ snap_rm), 32'd0);
        end
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        out_ready_i = 1'b0;
        chk("back_to_idle", {30'd0, in_ready_o, out_valid_o}, 32'b10);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got no end required end");
        $fatal(1, "timeout");
    end

    initial begin
        reset_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
        rs1_i = '0; rs2_i = '0; rm_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready",  32'(in_ready_o),  32'd1);
        chk("reset_out_valid", 32'(out_valid_o), 32'd0);
        chk("reset_rs1Sig",    32'(rs1Sig_o),    32'd0);
        @(negedge clk); reset_i = 1'b0;

        // 3.0 and 1.0
        do_op(mk(32'h40400000, 32'h3F800000, 10'sd1, 24'hC00000, C_NORM,
                 10'sd0, 24'h800000, C_NORM, 3'd0), 1, 1'b0, 0);
        // Smallest subnormal and the largest-leading-bit subnormal
        do_op(mk(32'h00000001, 32'h00400000, -10'sd149, 24'h800000, C_SUB,
                 -10'sd127, 24'h800000, C_SUB, 3'd1), 24, 1'b0, 0);
        // QNaN and -INF
        do_op(mk(32'h7FC00000, 32'hFF800000, 10'sd128, 24'hC00000, C_QNAN,
                 10'sd128, 24'h800000, C_INF, 3'd2), 1, 1'b0, 0);
        // SNaN and -0
        do_op(mk(32'h7F800001, 32'h80000000, 10'sd128, 24'h800001, C_SNAN,
                 -10'sd127, 24'h000000, C_ZERO, 3'd4), 1, 1'b0, 0);
        // Subnormal F=0x100 (S=15), rm=3 must survive changes during NORM;
        // out_ready held high early
        do_op(mk(32'h00000100, 32'h3F800000, -10'sd141, 24'h800000, C_SUB,
                 10'sd0, 24'h800000, C_NORM, 3'b011), 16, 1'b1, 0);
        // Normal + subnormal F=0x200000 (S=2)
        do_op(mk(32'hBF800000, 32'h80200000, 10'sd0, 24'h800000, C_NORM,
                 -10'sd128, 24'h800000, C_SUB, 3'd5), 3, 1'b0, 0);
        // 2.0 and -5.0 with a 10-cycle stall in DONE
        do_op(mk(32'h40000000, 32'hC0A00000, 10'sd1, 24'h800000, C_NORM,
                 10'sd2, 24'hA00000, C_NORM, 3'd6), 1, 1'b0, 10);
        // Second operation right after the stall
        do_op(mk(32'h00000003, 32'h7F7FFFFF, -10'sd148, 24'hC00000, C_SUB,
                 10'sd127, 24'hFFFFFF, C_NORM, 3'd7), 23, 1'b0, 0);

        // Asynchronous reset in the middle of NORM
        @(negedge clk);
        rs1_i = 32'h00000001; rs2_i = 32'h3F800000; rm_i = 3'd3; in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("mid_norm_busy", 32'(in_ready_o), 32'd0);
        reset_i = 1'b1;
        #1;
        chk("areset_in_ready",  32'(in_ready_o),  32'd1);
        chk("areset_out_valid", 32'(out_valid_o), 32'd0);
        chk("areset_data", rs1_o | rs2_o | 32'(rs1Sig_o) | 32'(rs2Sig_o)
                           | 32'(rs1Exp_o) | 32'(rs2Exp_o) | 32'(rs1Class_o)
                           | 32'(rs2Class_o) | 32'(rm_o), 32'd0);
        @(negedge clk); reset_i = 1'b0;

        do_op(mk(32'h40400000, 32'h3F800000, 10'sd1, 24'hC00000, C_NORM,
                 10'sd0, 24'h800000, C_NORM, 3'd2), 1, 1'b0, 0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
